// File: rtl/ip_axi_wr_cmd_splitter.sv
// Splits a word-granular write command into AXI bursts that never cross a 4 KiB
// boundary or exceed MAX_BURST_WORDS, issuing one burst at a time.
module ip_axi_wr_cmd_splitter #(
    parameter int ADDR_WIDTH      = 64,
    parameter int BUS_MULTIPLIER  = 1,
    parameter int MAX_BURST_WORDS = 256
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_len,
    output logic                  sys_write_req,
    output logic [ADDR_WIDTH-1:0] sys_write_addr,
    output logic [15:0]           sys_write_burst_size,
    input  logic                  sys_write_master_ready,
    input  logic                  sys_write_resp_valid,
    input  logic [1:0]            sys_write_resp,
    output logic                  sys_write_resp_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  done_err
);

    localparam int BYTES = 4 * BUS_MULTIPLIER;
    localparam int SHIFT = $clog2(BYTES);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CALC = 3'd1;
    localparam logic [2:0] S_REQ  = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    if ((1 << SHIFT) != BYTES) begin : g_bad_bm
        $error("BUS_MULTIPLIER must make the bus word a power of two bytes");
    end
    if (MAX_BURST_WORDS < 1 || MAX_BURST_WORDS > 256) begin : g_bad_max
        $error("MAX_BURST_WORDS must be in 1..256");
    end

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [31:0]           remaining_q, remaining_d;
    logic [15:0]           burst_q, burst_d;
    logic                  err_q, err_d;

    logic [12:0] to_4k_bytes;
    logic [31:0] words_to_4k;
    logic [31:0] burst_calc;
    logic        cmd_fire;
    logic        req_fire;
    logic        resp_fire;

    // 13 bits so an aligned address yields a full 4096 bytes rather than 0
    assign to_4k_bytes = 13'd4096 - {1'b0, cur_addr_q[11:0]};
    assign words_to_4k = 32'(to_4k_bytes >> SHIFT);

    always_comb begin
        burst_calc = remaining_q;
        if (burst_calc > 32'(MAX_BURST_WORDS)) begin
            burst_calc = 32'(MAX_BURST_WORDS);
        end
        if (burst_calc > words_to_4k) begin
            burst_calc = words_to_4k;
        end
    end

    assign cmd_fire  = cmd_valid & cmd_ready;
    assign req_fire  = (state_q == S_REQ) & sys_write_master_ready;
    assign resp_fire = (state_q == S_WAIT) & sys_write_resp_valid;

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        burst_d     = burst_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    cur_addr_d  = cmd_addr;
                    remaining_d = cmd_len;
                    err_d       = 1'b0;
                    state_d     = (cmd_len != 32'd0) ? S_CALC : S_DONE;
                end
            end
            S_CALC: begin
                burst_d = burst_calc[15:0];
                state_d = S_REQ;
            end
            S_REQ: begin
                if (req_fire) begin
                    cur_addr_d  = cur_addr_q + (ADDR_WIDTH'(burst_q) << SHIFT);
                    remaining_d = remaining_q - 32'(burst_q);
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (resp_fire) begin
                    err_d   = err_q | (sys_write_resp != 2'b00);
                    state_d = (remaining_q != 32'd0) ? S_CALC : S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            burst_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            burst_q     <= burst_d;
            err_q       <= err_d;
        end
    end

    // cmd_ready is held low while reset is asserted
    assign cmd_ready            = reset_n & (state_q == S_IDLE);
    assign sys_write_req        = (state_q == S_REQ);
    assign sys_write_addr       = cur_addr_q;
    assign sys_write_burst_size = burst_q;
    assign sys_write_resp_ready = (state_q == S_WAIT);
    assign busy                 = (state_q != S_IDLE);
    assign done                 = (state_q == S_DONE);
    assign done_err             = (state_q == S_DONE) & err_q;

endmodule

// File: tb/tb_ip_axi_wr_cmd_splitter.sv
// Self-checking bench for ip_axi_wr_cmd_splitter: directed scenarios plus
// random commands checked against an arithmetic burst-split model.
module tb_ip_axi_wr_cmd_splitter;

    localparam int AW    = 64;
    localparam int BM    = 1;
    localparam int MAXW  = 256;
    localparam int BYTES = 4 * BM;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [31:0]   cmd_len;
    logic          sys_write_req;
    logic [AW-1:0] sys_write_addr;
    logic [15:0]   sys_write_burst_size;
    logic          sys_write_master_ready;
    logic          sys_write_resp_valid;
    logic [1:0]    sys_write_resp;
    logic          sys_write_resp_ready;
    logic          busy;
    logic          done;
    logic          done_err;

    int nchk  = 0;
    int nfail = 0;

    ip_axi_wr_cmd_splitter #(
        .ADDR_WIDTH     (AW),
        .BUS_MULTIPLIER (BM),
        .MAX_BURST_WORDS(MAXW)
    ) dut (
        .clock                 (clock),
        .reset_n               (reset_n),
        .cmd_valid             (cmd_valid),
        .cmd_ready             (cmd_ready),
        .cmd_addr              (cmd_addr),
        .cmd_len               (cmd_len),
        .sys_write_req         (sys_write_req),
        .sys_write_addr        (sys_write_addr),
        .sys_write_burst_size  (sys_write_burst_size),
        .sys_write_master_ready(sys_write_master_ready),
        .sys_write_resp_valid  (sys_write_resp_valid),
        .sys_write_resp        (sys_write_resp),
        .sys_write_resp_ready  (sys_write_resp_ready),
        .busy                  (busy),
        .done                  (done),
        .done_err              (done_err)
    );

    always #5 clock = ~clock;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Runs one command; err_idx marks the burst answered with SLVERR,
    // stall_idx the burst whose acceptance is delayed by stall_n cycles.
    task automatic do_cmd(input logic [63:0] a, input logic [31:0] l,
                          input int err_idx, input int stall_idx,
                          input int stall_n, input int resp_dly);
        logic [63:0]  ea[$];
        int           es[$];
        logic [63:0]  cur;
        longint       rem;
        longint       w;
        longint       b;
        int           cyc;
        logic         exp_err;
        cur = a;
        rem = longint'(l);
        while (rem > 0) begin
            w = (4096 - longint'(cur % 4096)) / BYTES;
            b = rem;
            if (b > MAXW) b = MAXW;
            if (b > w) b = w;
            ea.push_back(cur);
            es.push_back(int'(b));
            cur = cur + 64'(b * BYTES);
            rem = rem - b;
        end
        nchk++;
        if (cmd_ready !== 1'b1) begin
            nfail++;
            $display("FAIL idle_cmd_ready: got %b want 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        step();
        cmd_valid = 1'b0;
        exp_err   = 1'b0;
        for (int i = 0; i < es.size(); i++) begin
            cyc = 0;
            while (sys_write_req !== 1'b1 && cyc < 50) begin
                nchk++;
                if (done !== 1'b0) begin
                    nfail++;
                    $display("FAIL early_done: burst %0d got %b want 0", i, done);
                end
                step();
                cyc++;
            end
            nchk++;
            if (cyc != 1) begin
                nfail++;
                $display("FAIL req_latency: burst %0d got %0d want 1 cycles", i, cyc);
                if (cyc >= 50) return;
            end
            nchk++;
            if (sys_write_addr !== ea[i] || sys_write_burst_size !== 16'(es[i])) begin
                nfail++;
                $display("FAIL burst_fields: burst %0d got %0h/%0d want %0h/%0d",
                         i, sys_write_addr, sys_write_burst_size, ea[i], es[i]);
            end
            nchk++;
            if (sys_write_resp_ready !== 1'b0 || busy !== 1'b1) begin
                nfail++;
                $display("FAIL req_ctrl: got rr=%b busy=%b want 0/1",
                         sys_write_resp_ready, busy);
            end
            if (i == stall_idx) begin
                for (int s = 0; s < stall_n; s++) begin
                    sys_write_resp_valid = 1'b1;
                    sys_write_resp       = 2'b11;
                    step();
                    nchk++;
                    if (sys_write_req !== 1'b1 || sys_write_addr !== ea[i] ||
                        sys_write_burst_size !== 16'(es[i]) ||
                        sys_write_resp_ready !== 1'b0) begin
                        nfail++;
                        $display("FAIL stall_hold: cyc %0d got %b/%0h/%0d rr=%b want 1/%0h/%0d rr=0",
                                 s, sys_write_req, sys_write_addr,
                                 sys_write_burst_size, sys_write_resp_ready,
                                 ea[i], es[i]);
                    end
                end
                sys_write_resp_valid = 1'b0;
                sys_write_resp       = 2'b00;
            end
            sys_write_master_ready = 1'b1;
            step();
            sys_write_master_ready = 1'b0;
            for (int d = 0; d < resp_dly; d++) begin
                nchk++;
                if (sys_write_req !== 1'b0 || sys_write_resp_ready !== 1'b1 ||
                    done !== 1'b0) begin
                    nfail++;
                    $display("FAIL outstanding: got req=%b rr=%b done=%b want 0/1/0",
                             sys_write_req, sys_write_resp_ready, done);
                end
                step();
            end
            nchk++;
            if (sys_write_req !== 1'b0 || sys_write_resp_ready !== 1'b1) begin
                nfail++;
                $display("FAIL wait_state: got req=%b rr=%b want 0/1",
                         sys_write_req, sys_write_resp_ready);
            end
            sys_write_resp_valid = 1'b1;
            sys_write_resp       = (i == err_idx) ? 2'b10 : 2'b00;
            if (i == err_idx) exp_err = 1'b1;
            step();
            sys_write_resp_valid = 1'b0;
            sys_write_resp       = 2'b00;
        end
        nchk++;
        if (done !== 1'b1 || done_err !== exp_err || sys_write_req !== 1'b0) begin
            nfail++;
            $display("FAIL done_pulse: got done=%b err=%b req=%b want 1/%b/0",
                     done, done_err, sys_write_req, exp_err);
        end
        step();
        nchk++;
        if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            nfail++;
            $display("FAIL back_to_idle: got done=%b busy=%b rdy=%b want 0/0/1",
                     done, busy, cmd_ready);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        nchk++;
        if ({sys_write_req, sys_write_resp_ready, busy, done, done_err, cmd_ready} !== 6'b0 ||
            sys_write_addr !== '0 || sys_write_burst_size !== 16'd0) begin
            nfail++;
            $display("FAIL reset_outputs: got %b addr=%0h size=%0d want 0",
                     {sys_write_req, sys_write_resp_ready, busy, done, done_err, cmd_ready},
                     sys_write_addr, sys_write_burst_size);
        end
        reset_n = 1'b1;
        step();
        nchk++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            nfail++;
            $display("FAIL reset_release: got rdy=%b busy=%b want 1/0", cmd_ready, busy);
        end
    endtask

    task automatic test_single();
        do_cmd(64'h1000, 32'd16, -1, -1, 0, 0);
    endtask

    task automatic test_4k_cross();
        do_cmd(64'h0FF0, 32'd16, -1, -1, 0, 2);
    endtask

    task automatic test_max_split();
        do_cmd(64'h0, 32'd600, -1, -1, 0, 1);
    endtask

    task automatic test_error_stall();
        do_cmd(64'h0, 32'd300, 0, 1, 5, 1);
    endtask

    task automatic test_zero_len();
        do_cmd(64'h2000, 32'd0, -1, -1, 0, 0);
    endtask

    task automatic test_back_to_back();
        do_cmd(64'h3FFC, 32'd2, -1, -1, 0, 0);
        do_cmd(64'h3000, 32'd1024, 3, 2, 1, 0);
    endtask

    task automatic test_reset_mid();
        int saw_done;
        cmd_valid = 1'b1;
        cmd_addr  = 64'h1000;
        cmd_len   = 32'd16;
        step();
        cmd_valid = 1'b0;
        step();
        sys_write_master_ready = 1'b1;
        step();
        sys_write_master_ready = 1'b0;
        nchk++;
        if (sys_write_resp_ready !== 1'b1) begin
            nfail++;
            $display("FAIL mid_setup: got rr=%b want 1", sys_write_resp_ready);
        end
        #2;
        reset_n = 1'b0;
        #1;
        nchk++;
        if ({sys_write_req, sys_write_resp_ready, busy, done, done_err} !== 5'b0 ||
            sys_write_addr !== '0 || sys_write_burst_size !== 16'd0) begin
            nfail++;
            $display("FAIL async_reset: got %b addr=%0h size=%0d want 0",
                     {sys_write_req, sys_write_resp_ready, busy, done, done_err},
                     sys_write_addr, sys_write_burst_size);
        end
        step();
        reset_n  = 1'b1;
        saw_done = 0;
        sys_write_resp_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            if (done !== 1'b0 || busy !== 1'b0) saw_done++;
        end
        sys_write_resp_valid = 1'b0;
        nchk++;
        if (saw_done != 0 || cmd_ready !== 1'b1) begin
            nfail++;
            $display("FAIL post_reset: got %0d active cycles rdy=%b want 0/1",
                     saw_done, cmd_ready);
        end
    endtask

    task automatic test_random();
        logic [63:0] a;
        logic [31:0] l;
        for (int n = 0; n < 12; n++) begin
            a = {16'h0, 16'($urandom), 32'($urandom)} & ~64'h3;
            l = 32'($urandom_range(0, 700));
            do_cmd(a, l, int'($urandom_range(0, 3)) - 1, int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        reset_n                = 1'b0;
        cmd_valid              = 1'b0;
        cmd_addr               = '0;
        cmd_len                = '0;
        sys_write_master_ready = 1'b0;
        sys_write_resp_valid   = 1'b0;
        sys_write_resp         = 2'b00;
        test_reset();
        test_single();
        test_4k_cross();
        test_max_split();
        test_error_stall();
        test_zero_len();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
